// File: rtl/mult_booth4_pipe.sv
// Pipelined radix-4 Booth multiplier with valid/ready flow control and a global stall.
// Optional completed-transfer counter on txn_count when MULT_TXN_CNT_EN is defined.
module mult_booth4_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
`ifdef MULT_TXN_CNT_EN
  ,
  output logic [15:0]          txn_count
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int ND = (WIDTH + 2) / 2;
  localparam int EW = 2 * ND;

  // Multiplier is extended by at least one bit so unsigned operands recode as non-negative.
  function automatic logic [PW-1:0] booth_mul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sm);
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] pp;
    logic signed [PW-1:0] acc;
    logic        [EW:0]   b_ext;
    logic        [2:0]    dig;
    a_ext = {{WIDTH{sm & a[WIDTH-1]}}, a};
    b_ext = {{(EW-WIDTH){sm & b[WIDTH-1]}}, b, 1'b0};
    acc   = '0;
    for (int i = 0; i < ND; i++) begin
      dig = b_ext[2*i +: 3];
      case (dig)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
    return acc;
  endfunction

  logic              advance;
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  a_p0_q;
  logic [WIDTH-1:0]  b_p0_q;
  logic              sm_p0_q;
  logic [PW-1:0]     chain [0:STAGES-2];
  logic [PW-1:0]     product_d;
  logic [PW-1:0]     product_q;

  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign product   = product_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= {vld_q[STAGES-2:0], in_valid};
    end
  end

  // Stage p0: operand capture
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      a_p0_q  <= multiplicand;
      b_p0_q  <= multiplier;
      sm_p0_q <= signed_mode;
    end
  end

  // Stage p1 onward: Booth reduction, then plain delay registers up to the output
  assign chain[0] = booth_mul(a_p0_q, b_p0_q, sm_p0_q);

  for (genvar k = 1; k <= STAGES - 2; k++) begin : g_mid
    logic [PW-1:0] prod_q;
    always_ff @(posedge clk) begin
      if (advance) begin
        prod_q <= chain[k-1];
      end
    end
    assign chain[k] = prod_q;
  end

  assign product_d = chain[STAGES-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_q <= '0;
    end else if (advance) begin
      product_q <= product_d;
    end
  end

`ifdef MULT_TXN_CNT_EN
  logic [15:0] txn_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q <= '0;
    end else if (vld_q[STAGES-1] && out_ready) begin
      txn_q <= txn_q + 16'd1;
    end
  end
  assign txn_count = txn_q;
`endif

endmodule

// File: tb/tb_mult_booth4_pipe.sv
// Directed and randomized bench for mult_booth4_pipe at (8,3), (16,2) and (16,6).
// The counter scenario runs only when MULT_TXN_CNT_EN is defined.
module tb_mult_booth4_pipe;
  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv8, sm8, or8, ir8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic [15:0] a16, b16;
  logic        sm16;
  logic        iv2, or2, ir2, ov2;
  logic        iv6, or6, ir6, ov6;
  logic [31:0] p2, p6;

`ifdef MULT_TXN_CNT_EN
  logic [15:0] txn8, txn2, txn6;
`endif

  mult_booth4_pipe #(.WIDTH(8), .STAGES(3)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .out_valid(ov8), .out_ready(or8), .product(p8)
`ifdef MULT_TXN_CNT_EN
    , .txn_count(txn8)
`endif
  );

  mult_booth4_pipe #(.WIDTH(16), .STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16), .out_valid(ov2), .out_ready(or2), .product(p2)
`ifdef MULT_TXN_CNT_EN
    , .txn_count(txn2)
`endif
  );

  mult_booth4_pipe #(.WIDTH(16), .STAGES(6)) u6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16), .out_valid(ov6), .out_ready(or6), .product(p6)
`ifdef MULT_TXN_CNT_EN
    , .txn_count(txn6)
`endif
  );

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic signed [31:0] sa, sb;
    if (s) begin
      sa = {{16{a[15]}}, a};
      sb = {{16{b[15]}}, b};
      return sa * sb;
    end
    return {16'b0, a} * {16'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    iv8 = 0; sm8 = 0; or8 = 0; a8 = 0; b8 = 0;
    iv2 = 0; or2 = 0; iv6 = 0; or6 = 0; sm16 = 0; a16 = 0; b16 = 0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov8); end
    checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_product: got %h expected 0000", p8); end
    tick();
    tick();
    checks++; if (ov2 !== 1'b0 || ov6 !== 1'b0) begin errors++; $display("FAIL reset_out_valid_16: got %b%b expected 00", ov2, ov6); end
    rst_n = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", ir8); end
    tick();
  endtask

  task automatic test_signed_min();
    or8 = 1; sm8 = 1; a8 = 8'h80; b8 = 8'h80; iv8 = 1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL min_in_ready: got %b expected 1", ir8); end
    tick();
    iv8 = 0;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL min_early_k: got %b expected 0", ov8); end
    tick();
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL min_early_k1: got %b expected 0", ov8); end
    tick();
    checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL min_valid_k2: got %b expected 1", ov8); end
    checks++; if (p8 !== 16'h4000) begin errors++; $display("FAIL min_product: got %h expected 4000", p8); end
    tick();
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL min_drop: got %b expected 0", ov8); end
  endtask

  task automatic test_corners();
    logic [7:0]  ta [0:5];
    logic [7:0]  tb [0:5];
    logic        ts [0:5];
    logic [15:0] te [0:5];
    int n;
    ta = '{8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h80, 8'hFF};
    tb = '{8'hFF, 8'hFF, 8'h01, 8'h80, 8'h80, 8'h00};
    ts = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    te = '{16'hFE01, 16'h0001, 16'hFFFF, 16'hC080, 16'h4000, 16'h0000};
    or8 = 1;
    for (int i = 0; i < 6; i++) begin
      a8 = ta[i]; b8 = tb[i]; sm8 = ts[i]; iv8 = 1;
      tick();
      iv8 = 0;
      n = 0;
      while (!ov8 && n < 10) begin tick(); n++; end
      checks++;
      if (ov8 !== 1'b1 || p8 !== te[i])
        begin errors++; $display("FAIL corner_%0d: got valid=%b product=%h expected valid=1 product=%h", i, ov8, p8, te[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va [0:2];
    logic [7:0]  vb [0:2];
    logic [15:0] ve [0:2];
    logic [15:0] got [$];
    va = '{8'h03, 8'h07, 8'hFC};
    vb = '{8'h05, 8'hFE, 8'hFC};
    ve = '{16'h000F, 16'hFFF2, 16'h0010};
    or8 = 1; sm8 = 1;
    for (int i = 0; i < 3; i++) begin
      a8 = va[i]; b8 = vb[i]; iv8 = 1;
      tick();
    end
    iv8 = 0; or8 = 0;
    #1;
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (ov8 !== 1'b1 || p8 !== 16'h000F || ir8 !== 1'b0)
        begin errors++; $display("FAIL stall_%0d: got valid=%b product=%h in_ready=%b expected 1 000F 0", s, ov8, p8, ir8); end
      tick();
    end
    or8 = 1;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (ov8) got.push_back(p8);
      tick();
    end
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got.size()) begin errors++; $display("FAIL b2b_%0d: got none expected %h", i, ve[i]); end
      else if (got[i] !== ve[i]) begin errors++; $display("FAIL b2b_%0d: got %h expected %h", i, got[i], ve[i]); end
    end
  endtask

  task automatic test_reset_inflight();
    int seen;
    or8 = 1; sm8 = 0;
    a8 = 8'd5; b8 = 8'd6; iv8 = 1; tick();
    a8 = 8'd2; b8 = 8'd3; tick();
    iv8 = 0; tick();
    checks++;
    if (ov8 !== 1'b1 || p8 !== 16'h001E) begin errors++; $display("FAIL inflight_pre: got valid=%b product=%h expected 1 001E", ov8, p8); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || p8 !== 16'h0000) begin errors++; $display("FAIL inflight_clear: got valid=%b product=%h expected 0 0000", ov8, p8); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL inflight_in_ready: got %b expected 1", ir8); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ov8) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL inflight_stale: got %0d results expected 0", seen); end
  endtask

  task automatic test_latency16();
    int l2, l6;
    logic [31:0] g2, g6;
    l2 = 0; l6 = 0; g2 = '0; g6 = '0;
    or2 = 1; or6 = 1; sm16 = 1; a16 = 16'h8000; b16 = 16'h7FFF; iv2 = 1; iv6 = 1;
    tick();
    iv2 = 0; iv6 = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ov2 && l2 == 0) begin l2 = c - 1; g2 = p2; end
      if (ov6 && l6 == 0) begin l6 = c - 1; g6 = p6; end
      tick();
    end
    checks++; if (l2 != 1) begin errors++; $display("FAIL lat_s2: got %0d expected 1", l2); end
    checks++; if (g2 !== 32'hC0008000) begin errors++; $display("FAIL lat_s2_product: got %h expected C0008000", g2); end
    checks++; if (l6 != 5) begin errors++; $display("FAIL lat_s6: got %0d expected 5", l6); end
    checks++; if (g6 !== 32'hC0008000) begin errors++; $display("FAIL lat_s6_product: got %h expected C0008000", g6); end
  endtask

  function automatic logic [15:0] pick16();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 16'hFFFF;
    if (r == 1) return 16'h8000;
    if (r == 2) return 16'h0000;
    return 16'($urandom);
  endfunction

  task automatic test_random16();
    logic [31:0] q2 [$];
    logic [31:0] q6 [$];
    logic [31:0] e;
    int n2, n6, cyc;
    n2 = 0; n6 = 0; cyc = 0;
    while ((n2 < 1000 || n6 < 1000 || q2.size() > 0 || q6.size() > 0) && cyc < 20000) begin
      a16 = pick16(); b16 = pick16(); sm16 = 1'($urandom_range(0, 1));
      iv2 = (n2 < 1000) && ($urandom_range(0, 3) != 0);
      iv6 = (n6 < 1000) && ($urandom_range(0, 3) != 0);
      or2 = ($urandom_range(0, 3) != 0);
      or6 = ($urandom_range(0, 3) != 0);
      #1;
      e = ref_mul(a16, b16, sm16);
      if (iv2 && ir2) begin q2.push_back(e); n2++; end
      if (iv6 && ir6) begin q6.push_back(e); n6++; end
      if (ov2 && or2) begin
        checks++;
        if (q2.size() == 0) begin errors++; $display("FAIL rand_s2_extra: got %h expected none", p2); end
        else begin e = q2.pop_front(); if (p2 !== e) begin errors++; $display("FAIL rand_s2: got %h expected %h", p2, e); end end
      end
      if (ov6 && or6) begin
        checks++;
        if (q6.size() == 0) begin errors++; $display("FAIL rand_s6_extra: got %h expected none", p6); end
        else begin e = q6.pop_front(); if (p6 !== e) begin errors++; $display("FAIL rand_s6: got %h expected %h", p6, e); end end
      end
      tick();
      cyc++;
    end
    iv2 = 0; iv6 = 0;
    checks++;
    if (n2 < 1000 || n6 < 1000 || q2.size() != 0 || q6.size() != 0)
      begin errors++; $display("FAIL rand_drain: got accepted %0d/%0d pending %0d/%0d expected 1000/1000 0/0", n2, n6, q2.size(), q6.size()); end
  endtask

`ifdef MULT_TXN_CNT_EN
  task automatic test_txn_count();
    rst_n = 1'b0;
    #1;
    checks++; if (txn8 !== 16'h0000) begin errors++; $display("FAIL txn_reset: got %h expected 0000", txn8); end
    tick();
    rst_n = 1'b1;
    or8 = 1; sm8 = 0; a8 = 8'd3; b8 = 8'd4; iv8 = 1;
    #1;
    for (int i = 0; i < 65537; i++) tick();
    iv8 = 0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (txn8 !== 16'h0001) begin errors++; $display("FAIL txn_wrap: got %h expected 0001", txn8); end
  endtask
`endif

  initial begin
    test_reset();
    test_signed_min();
    test_corners();
    test_back_to_back();
    test_reset_inflight();
    test_latency16();
    test_random16();
`ifdef MULT_TXN_CNT_EN
    test_txn_count();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
